// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the 32 x 32 MIPS register file: clears the file after reset,
// then arbitrates ALU writeback (priority) against a small load-writeback queue.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              alu_byte,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_byte,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic              hazard_stall,
    output logic              regWrite,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              byteOperations,
    output logic              init_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              regWrite_q, regWrite_d;
    logic [ADDR_W-1:0] writeReg_q, writeReg_d;
    logic [DATA_W-1:0] writeData_q, writeData_d;
    logic              byteOp_q, byteOp_d;

    logic [ADDR_W-1:0] qReg_q  [DEPTH];
    logic [DATA_W-1:0] qData_q [DEPTH];
    logic [DEPTH-1:0]  qByte_q;
    logic [DEPTH-1:0]  qLive_q;
    logic [PTR_W-1:0]  rdPtr_q, wrPtr_q;
    logic [PTR_W:0]    count_q, count_d;

    logic aluIssue, headLive, push, pop, pushLive;

    assign mem_ready = (state_q == RUN) && (count_q < CNT_MAX);
    assign init_busy = (state_q == INIT);
    assign headLive  = (count_q != '0) && qLive_q[rdPtr_q];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        byteOp_d    = byteOp_q;
        aluIssue    = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        case (state_q)
            INIT: begin
                regWrite_d  = 1'b1;
                writeReg_d  = cnt_q;
                writeData_d = '0;
                byteOp_d    = 1'b0;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = RUN;
            end
            RUN: begin
                aluIssue = alu_valid && (alu_reg != '0);
                push     = mem_valid && mem_ready;
                // Dead heads drain even while the ALU owns the port.
                pop      = (count_q != '0) && (!qLive_q[rdPtr_q] || !aluIssue);
                if (aluIssue) begin
                    regWrite_d  = 1'b1;
                    writeReg_d  = alu_reg;
                    writeData_d = alu_data;
                    byteOp_d    = alu_byte;
                end else if (headLive) begin
                    regWrite_d  = 1'b1;
                    writeReg_d  = qReg_q[rdPtr_q];
                    writeData_d = qData_q[rdPtr_q];
                    byteOp_d    = qByte_q[rdPtr_q];
                end
            end
            default: state_d = INIT;
        endcase
        count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        // A load colliding with a same-cycle ALU write to its register is the older write.
        pushLive = (mem_reg != '0) && !(aluIssue && (alu_reg == mem_reg));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
            byteOp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
            byteOp_q    <= byteOp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qLive_q <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (aluIssue && (qReg_q[i] == alu_reg)) qLive_q[i] <= 1'b0;
            end
            if (pop) begin
                qLive_q[rdPtr_q] <= 1'b0;
                rdPtr_q          <= rdPtr_q + PTR_W'(1);
            end
            if (push) begin
                qReg_q[wrPtr_q]  <= mem_reg;
                qData_q[wrPtr_q] <= mem_data;
                qByte_q[wrPtr_q] <= mem_byte;
                qLive_q[wrPtr_q] <= pushLive;
                wrPtr_q          <= wrPtr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        hazard_stall = init_busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (qLive_q[i] && (((rd_reg1 != '0) && (qReg_q[i] == rd_reg1)) ||
                               ((rd_reg2 != '0) && (qReg_q[i] == rd_reg2))))
                hazard_stall = 1'b1;
        end
        if (regWrite_q && (writeReg_q != '0) &&
            ((writeReg_q == rd_reg1) || (writeReg_q == rd_reg2)))
            hazard_stall = 1'b1;
    end

    assign regWrite       = regWrite_q;
    assign write_reg      = writeReg_q;
    assign write_data     = writeData_q;
    assign byteOperations = byteOp_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; every observed write is popped from an
// expected-write scoreboard, with explicit checks on handshake and stall outputs.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_byte, mem_valid, mem_byte, mem_ready;
    logic [4:0]  alu_reg, mem_reg, rd_reg1, rd_reg2, write_reg;
    logic [31:0] alu_data, mem_data, write_data;
    logic        hazard_stall, regWrite, byteOperations, init_busy;

    int compared   = 0;
    int mismatched = 0;
    logic [37:0] expQ[$];

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_byte(alu_byte),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg),
        .mem_data(mem_data), .mem_byte(mem_byte),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .hazard_stall(hazard_stall),
        .regWrite(regWrite), .write_reg(write_reg), .write_data(write_data),
        .byteOperations(byteOperations), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expectWrite(input logic [4:0] r, input logic [31:0] d, input logic b);
        expQ.push_back({r, b, d});
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic ab, input logic mv, input logic [4:0] mr,
                                 input logic [31:0] md, input logic mb);
        alu_valid = av; alu_reg = ar; alu_data = ad; alu_byte = ab;
        mem_valid = mv; mem_reg = mr; mem_data = md; mem_byte = mb;
    endtask

    // Advance one cycle and match any write on the port against the scoreboard head.
    task automatic tick();
        logic [37:0] e;
        @(posedge clk);
        #1;
        if (regWrite === 1'b1) begin
            compared++;
            assert (expQ.size() != 0) else begin
                mismatched++;
                $error("[TB] FAIL unexpected_write: observed reg %0d data %0h expected none",
                       write_reg, write_data);
            end
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("write_entry", {26'd0, write_reg, byteOperations, write_data}, {26'd0, e});
            end
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic runSweep();
        for (int i = 0; i < 32; i++) expectWrite(5'(i), 32'd0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            tick();
            checkOutput("init_regWrite", {63'd0, regWrite}, 64'd1);
            checkOutput("init_busy", {63'd0, init_busy}, (i < 31) ? 64'd1 : 64'd0);
        end
        checkOutput("sweep_mem_ready", {63'd0, mem_ready}, 64'd1);
        tick();
        checkOutput("post_init_regWrite", {63'd0, regWrite}, 64'd0);
        checkOutput("sweep_drained", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1; rd_reg1 = '0; rd_reg2 = '0;
        idle();
        tick(); tick();
        checkOutput("rst_regWrite", {63'd0, regWrite}, 64'd0);
        checkOutput("rst_write_reg", {59'd0, write_reg}, 64'd0);
        checkOutput("rst_write_data", {32'd0, write_data}, 64'd0);
        checkOutput("rst_byteOps", {63'd0, byteOperations}, 64'd0);
        checkOutput("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
        checkOutput("rst_init_busy", {63'd0, init_busy}, 64'd1);
        checkOutput("rst_hazard", {63'd0, hazard_stall}, 64'd1);
        reset = 1'b0;
        runSweep();
        checkOutput("run_hazard_idle", {63'd0, hazard_stall}, 64'd0);

        // Single ALU write
        applyStimulus(1'b1, 5'd2, 32'h7F8, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        expectWrite(5'd2, 32'h7F8, 1'b1);
        tick();
        checkOutput("alu_regWrite", {63'd0, regWrite}, 64'd1);
        idle(); tick();
        checkOutput("alu_then_idle", {63'd0, regWrite}, 64'd0);

        // ALU priority over queued loads; third load refused when full
        applyStimulus(1'b1, 5'd5, 32'h55, 1'b0, 1'b1, 5'd3, 32'h33, 1'b1);
        expectWrite(5'd5, 32'h55, 1'b0);
        tick();
        checkOutput("q1_mem_ready", {63'd0, mem_ready}, 64'd1);
        applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 1'b1, 5'd4, 32'h44, 1'b0);
        expectWrite(5'd6, 32'h66, 1'b1);
        tick();
        checkOutput("q2_mem_ready", {63'd0, mem_ready}, 64'd0);
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 1'b1, 5'd10, 32'hAA, 1'b0);
        expectWrite(5'd7, 32'h77, 1'b0);
        expectWrite(5'd3, 32'h33, 1'b1);
        expectWrite(5'd4, 32'h44, 1'b0);
        tick();
        checkOutput("full_mem_ready", {63'd0, mem_ready}, 64'd0);
        idle();
        tick();
        checkOutput("load3_regWrite", {63'd0, regWrite}, 64'd1);
        tick();
        checkOutput("load4_regWrite", {63'd0, regWrite}, 64'd1);
        tick();
        checkOutput("drain_regWrite", {63'd0, regWrite}, 64'd0);
        checkOutput("drain_mem_ready", {63'd0, mem_ready}, 64'd1);
        checkOutput("order_drained", 64'(expQ.size()), 64'd0);

        // Write-after-write: ALU kills a queued load to the same register
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd9, 32'h99, 1'b0);
        tick();
        checkOutput("waw_push_nowrite", {63'd0, regWrite}, 64'd0);
        applyStimulus(1'b1, 5'd9, 32'hA9, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        expectWrite(5'd9, 32'hA9, 1'b0);
        tick();
        idle(); tick();
        checkOutput("waw_dead_pop", {63'd0, regWrite}, 64'd0);
        tick();
        checkOutput("waw_empty_ready", {63'd0, mem_ready}, 64'd1);

        // Same-cycle load and ALU write to one register: load is older
        applyStimulus(1'b1, 5'd11, 32'hB1, 1'b1, 1'b1, 5'd11, 32'hB2, 1'b0);
        expectWrite(5'd11, 32'hB1, 1'b1);
        tick();
        idle(); tick();
        checkOutput("same_cycle_dead", {63'd0, regWrite}, 64'd0);

        // Read hazard on a queued load
        rd_reg1 = 5'd8;
        tick();
        checkOutput("haz_before", {63'd0, hazard_stall}, 64'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd8, 32'h88, 1'b0);
        expectWrite(5'd8, 32'h88, 1'b0);
        tick();
        idle();
        checkOutput("haz_queued", {63'd0, hazard_stall}, 64'd1);
        tick();
        checkOutput("haz_writing", {63'd0, hazard_stall}, 64'd1);
        tick();
        checkOutput("haz_cleared", {63'd0, hazard_stall}, 64'd0);

        // Register 0: no stall, no write
        rd_reg1 = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1);
        tick();
        idle();
        checkOutput("r0_no_stall", {63'd0, hazard_stall}, 64'd0);
        tick();
        checkOutput("r0_no_write", {63'd0, regWrite}, 64'd0);

        // Reset with two loads still queued
        applyStimulus(1'b1, 5'd14, 32'hE4, 1'b0, 1'b1, 5'd12, 32'hC2, 1'b0);
        expectWrite(5'd14, 32'hE4, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd15, 32'hF5, 1'b0, 1'b1, 5'd13, 32'hD3, 1'b0);
        expectWrite(5'd15, 32'hF5, 1'b0);
        tick();
        checkOutput("pre_rst_full", {63'd0, mem_ready}, 64'd0);
        idle();
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_regWrite", {63'd0, regWrite}, 64'd0);
        checkOutput("mid_rst_write_reg", {59'd0, write_reg}, 64'd0);
        checkOutput("mid_rst_init_busy", {63'd0, init_busy}, 64'd1);
        checkOutput("mid_rst_mem_ready", {63'd0, mem_ready}, 64'd0);
        reset = 1'b0;
        runSweep();
        tick(); tick();
        checkOutput("flushed_no_write", {63'd0, regWrite}, 64'd0);
        checkOutput("final_scoreboard", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the single write port of the 32 x 32-bit register file in the MIPS datapath. After reset it clears every register, one register per cycle. It then shares the write port between the ALU writeback path, which has priority, and the load/memory writeback path, which is buffered in a small queue. It also raises a read-hazard stall while a queued load still targets a source register.

## Interface
- DATA_W, 32, data width of the write port
- ADDR_W, 5, register index width
- DEPTH, 2, load-queue entries (power of two, at least 2)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU writeback request; always accepted in RUN, never back-pressured
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_byte  in  1  byte-operation flag for the ALU write
- mem_valid  in  1  load writeback request
- mem_ready  out  1  load queue can accept a request
- mem_reg  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_byte  in  1  byte-operation flag for the load write
- rd_reg1, rd_reg2  in  ADDR_W  current decode-stage source registers
- hazard_stall  out  1  decode must stall
- regWrite  out  1  register-file write enable (registered)
- write_reg  out  ADDR_W  register-file write index (registered)
- write_data  out  DATA_W  register-file write data (registered)
- byteOperations  out  1  register-file byte-operation flag (registered)
- init_busy  out  1  clear sweep in progress

## Operation
- FSM states: INIT and RUN. reset forces INIT and the sweep counter to 0.
- INIT:
  - Each cycle, emit regWrite=1, write_reg=counter, write_data=0, byteOperations=0, then increment the counter.
  - After index 31 is issued, go to RUN.
  - init_busy=1 and mem_ready=0 throughout INIT. alu_valid is ignored.
- RUN arbitration, evaluated each cycle, with result registered onto the write port at the next edge:
  1. If alu_valid=1 and alu_reg!=0, issue the ALU request.
  2. Otherwise, if the queue head is live, pop it and issue it.
  3. Otherwise, regWrite=0. write_reg, write_data and byteOperations hold their last values.
- A request with destination 0 is never issued: an ALU request is dropped, and a queue entry is popped without a write.
- Load queue:
  - FIFO of {reg, data, byte, live}.
  - Push when mem_valid && mem_ready.
  - mem_ready = (state==RUN) && (count<DEPTH), computed from registered count. A push is refused when the queue is full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
- Write-after-write ordering:
  - An ALU write to register R clears the live bit of every queued entry with reg==R.
  - A load pushed in the same cycle as an ALU write to the same R is treated as older and is pushed with live=0.
  - Dead entries are popped at the head without issuing a write, one per cycle. This pop is allowed in the same cycle as an ALU issue.
- hazard_stall (combinational) = init_busy, OR any live queue entry with reg equal to a nonzero rd_reg1 or rd_reg2, OR (regWrite && write_reg!=0 && write_reg equals rd_reg1 or rd_reg2).
- No forwarding is performed; register 0 never raises a stall.

## Timing
- Reset values:
  - regWrite=0, write_reg=0, write_data=0, byteOperations=0.
  - mem_ready=0, init_busy=1, hazard_stall=1.
  - Queue empty, all live bits 0.
- INIT lasts exactly 32 cycles after reset deasserts. init_busy falls on the edge after index 31 is written, and mem_ready can rise in that same cycle.
- ALU request in cycle N: regWrite=1 during cycle N+1.
- Load accepted in cycle N with no competing ALU traffic: regWrite=1 during cycle N+2.
- A load is delayed one cycle for each cycle the ALU wins.
- Reset asserted mid-operation: the queue is flushed with no writes issued, the outputs return to their reset values, and INIT restarts from index 0 at the next cycle.
- Back-to-back issues are allowed: regWrite can remain 1 on consecutive cycles.

## Test plan
- Release reset and hold the inputs idle -> 32 consecutive writes of 0 to registers 0..31, init_busy=1 for those 32 cycles, then mem_ready=1 and regWrite=0.
- After INIT, alu_valid with alu_reg=2 and alu_data=32'h7F8 -> next cycle regWrite=1, write_reg=2, write_data=32'h7F8, byteOperations=alu_byte.
- Push loads to registers 3 and 4 while the ALU writes registers 5, 6 and 7 on consecutive cycles -> mem_ready=0 after 2 pushes, and issue order is 5, 6, 7, 3, 4.
- Queue a load to register 9, then an ALU write to register 9 while the load is still queued -> exactly one write to register 9, carrying the ALU data, and the dead entry is popped silently.
- Load to register 8 queued with rd_reg1=8 -> hazard_stall=1 until the cycle after the write issues. With rd_reg1=0 and a load to register 0 -> no stall and no write.
- Assert reset while 2 entries are queued -> no write of the queued data, and the INIT sweep restarts at index 0.
